// File: rtl/phase_gen_n.sv
// Multi-phase non-overlapping strobe generator: one-hot PH enables with programmable
// width, fixed dead-time gap, free-run/single-step modes and round-complete signalling.
module phase_gen_n #(
    parameter int unsigned PHASES = 2,
    parameter int unsigned DIV_W  = 4,
    parameter int unsigned GAP    = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              MODE,
    input  logic              STEP,
    input  logic [DIV_W-1:0]  DIV,
    output logic [PHASES-1:0] PH,
    output logic              O_S,
    output logic              CYC_DONE,
    output logic              BUSY
);

    localparam int unsigned IDX_W = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int unsigned CNT_W = (DIV_W > 2) ? DIV_W : 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHASES - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t             state, stateN;
    logic [IDX_W-1:0]   idx, idxN;
    logic [CNT_W-1:0]   cnt, cntN;
    logic [DIV_W-1:0]   divQ, divN;
    logic               phaseDone;
    logic               lastN;
    logic [PHASES-1:0]  phN;

    // State, counters and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            divQ     <= '0;
            PH       <= '0;
            O_S      <= 1'b1;
            CYC_DONE <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state    <= stateN;
            idx      <= idxN;
            cnt      <= cntN;
            divQ     <= divN;
            PH       <= phN;
            CYC_DONE <= lastN;
            BUSY     <= (stateN != S_IDLE);
            // CYC_DONE marks the current cycle as the round's last one
            if (CYC_DONE) begin
                O_S <= ~O_S;
            end
        end
    end

    // Next-state logic; outputs are looked ahead one cycle so they can be registered
    always_comb begin
        stateN    = state;
        idxN      = idx;
        cntN      = cnt;
        divN      = divQ;
        phaseDone = 1'b0;
        lastN     = 1'b0;
        phN       = '0;

        case (state)
            S_IDLE: begin
                if ((!MODE && EN) || (MODE && STEP)) begin
                    stateN = S_ACTIVE;
                    idxN   = '0;
                    cntN   = '0;
                    divN   = DIV;
                end
            end
            S_ACTIVE: begin
                if (cnt == CNT_W'(divQ)) begin
                    if (GAP > 0) begin
                        stateN = S_GAP;
                        cntN   = '0;
                    end else begin
                        phaseDone = 1'b1;
                    end
                end else begin
                    cntN = cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt == GAP_END) begin
                    phaseDone = 1'b1;
                end else begin
                    cntN = cnt + CNT_W'(1);
                end
            end
            default: begin
                stateN = S_IDLE;
                idxN   = '0;
                cntN   = '0;
            end
        endcase

        // Phase advance; a finished round either wraps seamlessly or parks in IDLE
        if (phaseDone) begin
            cntN = '0;
            if (idx == LAST_IDX) begin
                idxN = '0;
                if (!MODE && EN) begin
                    stateN = S_ACTIVE;
                    divN   = DIV;
                end else begin
                    stateN = S_IDLE;
                end
            end else begin
                stateN = S_ACTIVE;
                idxN   = idx + IDX_W'(1);
                divN   = DIV;
            end
        end

        if (GAP > 0) begin
            lastN = (idxN == LAST_IDX) && (stateN == S_GAP) && (cntN == GAP_END);
        end else begin
            lastN = (idxN == LAST_IDX) && (stateN == S_ACTIVE) && (cntN == CNT_W'(divN));
        end

        if (stateN == S_ACTIVE) begin
            phN = PHASES'(1) << idxN;
        end
    end

endmodule
